nonce_result_scanner: RTL and testbench

- Consumer of the hash records `bitcoin_hash` writes to shared memory.
- Once the miner signals `done`, reads word H0 of each per-nonce hash, finds the smallest, and compares it against a 32-bit difficulty target.
- Writes a 3-word result record back to memory.
- Sits beside the miner on the same single-port memory bus, arbitrated at top level; it is the reader of the miner's output region.

---
 rtl/nonce_result_scanner.sv | 156 +++++++++++++++
 tb/tb_nonce_result_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner
// Scans word H0 of each per-nonce hash record left in shared memory by the
// miner. It keeps the smallest value (ties keep the earlier nonce), compares
// it against a 32-bit difficulty target, and writes a 3-word result record
// {found, best_nonce, best_hash} starting at result_addr.
//
// Optional build macro: SCAN_EARLY_EXIT_EN. When it is defined, the scan stops
// at the first nonce whose H0 < target.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   start, hash_addr,           start a scan; the address and target inputs
//   result_addr, target         are latched when start is accepted in IDLE
//   done                        one-cycle pulse once the record is written
//   found, best_nonce,          result of the last scan, held until the
//   best_hash                   next scan finishes
//   mem_clk, mem_we, mem_addr,  single-port memory master (registered)
//   mem_write_data,
//   mem_read_data               read data, valid the cycle after mem_addr
module nonce_result_scanner #(
   parameter int NUM_NONCES     = 16,
   parameter int WORDS_PER_HASH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] hash_addr,
   input  logic [15:0] result_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [15:0] best_nonce,
   output logic [31:0] best_hash,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [15:0] LAST   = 16'(NUM_NONCES - 1);
   localparam logic [15:0] STRIDE = 16'(WORDS_PER_HASH);

   typedef enum logic [2:0] {IDLE, READ, WAIT, CAPT, WR0, WR1, WR2, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] idx, min_idx, rd_addr, res_addr;
   logic [31:0] min_val, tgt;
   logic        lower, last, early;
   logic [31:0] min_nxt;
   logic [15:0] min_idx_nxt;

   assign mem_clk = clk;

   // Strict compare, so equal values keep the earlier nonce.
   assign lower       = mem_read_data < min_val;
   assign min_nxt     = lower ? mem_read_data : min_val;
   assign min_idx_nxt = lower ? idx : min_idx;
   assign last        = (idx == LAST);

`ifdef SCAN_EARLY_EXIT_EN
   // The first hit is necessarily the running minimum, because every earlier
   // value was >= target.
   assign early = mem_read_data < tgt;
`else
   assign early = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    state_nxt = WAIT;
         WAIT:    state_nxt = CAPT;
         CAPT:    state_nxt = (last || early) ? WR0 : READ;
         WR0:     state_nxt = WR1;
         WR1:     state_nxt = WR2;
         WR2:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side outputs are registered. Each one therefore shows the action
   // of the state before: the address set in READ is on the bus during WAIT,
   // and its data arrives during CAPT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done           <= 1'b0;
         found          <= 1'b0;
         best_nonce     <= '0;
         best_hash      <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         idx            <= '0;
         min_idx        <= '0;
         min_val        <= '1;
         rd_addr        <= '0;
         res_addr       <= '0;
         tgt            <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               tgt      <= target;
               res_addr <= result_addr;
               rd_addr  <= hash_addr;
               idx      <= '0;
               min_val  <= '1;
               min_idx  <= '0;
            end
            READ: begin
               mem_we   <= 1'b0;
               mem_addr <= rd_addr;
            end
            CAPT: begin
               min_val <= min_nxt;
               min_idx <= min_idx_nxt;
               if (last || early) begin
                  found      <= min_nxt < tgt;
                  best_nonce <= min_idx_nxt;
                  best_hash  <= min_nxt;
               end else begin
                  idx     <= idx + 16'd1;
                  rd_addr <= rd_addr + STRIDE;   // 16-bit wrap intended
               end
            end
            WR0: begin
               mem_we         <= 1'b1;
               mem_addr       <= res_addr;
               mem_write_data <= {31'b0, found};
            end
            WR1: begin
               mem_addr       <= res_addr + 16'd1;
               mem_write_data <= {16'b0, best_nonce};
            end
            WR2: begin
               mem_addr       <= res_addr + 16'd2;
               mem_write_data <= best_hash;
            end
            DONE: begin
               mem_we <= 1'b0;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Self-checking bench for nonce_result_scanner. A behavioural memory model
// sits on the bus. Expected results come from a plain loop over the memory
// contents: a minimum search with strict compare, honouring the early-exit
// build.
module tb_nonce_result_scanner;

   localparam int N      = 16;
   localparam int STRIDE = 8;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [15:0] hash_addr, result_addr;
   logic [31:0] target;
   logic        done, found, mem_clk, mem_we;
   logic [15:0] best_nonce, mem_addr;
   logic [31:0] best_hash, mem_write_data, mem_read_data;

   logic [31:0] mem [0:65535];
   logic        tb_we;
   logic [15:0] tb_addr;
   logic [31:0] tb_data;

   int n_chk = 0, n_fail = 0, done_cnt = 0;

   nonce_result_scanner #(.NUM_NONCES(N), .WORDS_PER_HASH(STRIDE)) dut (
      .clk(clk), .reset(reset), .start(start), .hash_addr(hash_addr),
      .result_addr(result_addr), .target(target), .done(done), .found(found),
      .best_nonce(best_nonce), .best_hash(best_hash), .mem_clk(mem_clk),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data));

   always #5 clk = ~clk;

   always @(posedge mem_clk) begin
      if (mem_we) mem[mem_addr] <= mem_write_data;
      if (tb_we)  mem[tb_addr]  <= tb_data;
      mem_read_data <= mem[mem_addr];
   end

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_addr = a; tb_data = d;
      @(posedge clk); #1 tb_we = 1'b0;
   endtask

   function automatic logic [15:0] nadr(input logic [15:0] ha, input int i);
      return ha + 16'(i * STRIDE);
   endfunction

   task automatic model(input logic [15:0] ha, input logic [31:0] tgt,
                        output logic [31:0] mn, output logic [15:0] mi,
                        output logic f, output int lat);
      logic [31:0] v;
      mn = '1; mi = '0; lat = 3 * N + 4;
      for (int i = 0; i < N; i++) begin
         v = mem[nadr(ha, i)];
         if (v < mn) begin mn = v; mi = 16'(i); end
`ifdef SCAN_EARLY_EXIT_EN
         if (v < tgt) begin lat = 3 * (i + 1) + 4; break; end
`endif
      end
      f = (mn < tgt);
   endtask

   // Run one scan and check the latency, the held outputs and the written
   // record. With ign set, a second start carrying different inputs is
   // pulsed while the scanner is in READ; it must be ignored.
   task automatic scan(input string nm, input logic [15:0] ha, input logic [15:0] ra,
                       input logic [31:0] tgt, input bit ign);
      logic [31:0] mn; logic [15:0] mi; logic f; int lat, cyc, cnt0;
      model(ha, tgt, mn, mi, f, lat);
      cnt0 = done_cnt;
      @(negedge clk);
      hash_addr = ha; result_addr = ra; target = tgt; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (ign) begin
         start = 1'b1; hash_addr = ~ha; result_addr = ra + 16'd16; target = ~tgt;
      end
      cyc = 0;
      for (int c = 1; c <= 3 * N + 20; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin start = 1'b0; hash_addr = ha; result_addr = ra; target = tgt; end
         if (done) begin cyc = c; break; end
      end
      chk({nm, "_latency"}, 32'(cyc), 32'(lat));
      chk({nm, "_found"}, {31'b0, found}, {31'b0, f});
      chk({nm, "_best_nonce"}, {16'b0, best_nonce}, {16'b0, mi});
      chk({nm, "_best_hash"}, best_hash, mn);
      chk({nm, "_rec0"}, mem[ra], {31'b0, f});
      chk({nm, "_rec1"}, mem[ra + 16'd1], {16'b0, mi});
      chk({nm, "_rec2"}, mem[ra + 16'd2], mn);
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
      chk({nm, "_done_count"}, 32'(done_cnt - cnt0), 32'd1);
      chk({nm, "_held"}, best_hash, mn);
   endtask

   task automatic fill_desc(input logic [15:0] ha);
      for (int i = 0; i < N; i++) poke(nadr(ha, i), 32'h9000_0000 - 32'(i));
   endtask

   task automatic fill_rand(input logic [15:0] ha);
      for (int i = 0; i < N; i++) poke(nadr(ha, i), $urandom);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      hash_addr = '0; result_addr = '0; target = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_found", {31'b0, found}, 32'd0);
      chk("rst_best_nonce", {16'b0, best_nonce}, 32'd0);
      chk("rst_best_hash", best_hash, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_write_data, 32'd0);
      @(negedge clk) reset = 1'b0;

      // Descending values: the minimum is the last nonce, and it is no hit.
      fill_desc(16'h1000);
      scan("desc", 16'h1000, 16'h4000, 32'h8000_0000, 1'b0);

      // Tie at nonces 5 and 9: the earlier one wins.
      poke(nadr(16'h1000, 5), 32'h0000_1234);
      poke(nadr(16'h1000, 9), 32'h0000_1234);
      scan("tie", 16'h1000, 16'h4000, 32'h8000_0000, 1'b0);

      // Two hits below target at nonces 3 and 7.
      fill_desc(16'h2000);
      poke(nadr(16'h2000, 3), 32'h10);
      poke(nadr(16'h2000, 7), 32'h01);
      scan("early", 16'h2000, 16'h4100, 32'h100, 1'b0);

      // Address wrap from 0xFFF8, and target 0 never yields a hit.
      fill_rand(16'hFFF8);
      scan("wrap", 16'hFFF8, 16'h8000, 32'h0, 1'b0);

      // All-ones data against an all-ones target: no hit, nonce 0.
      for (int i = 0; i < N; i++) poke(nadr(16'h3000, i), 32'hFFFF_FFFF);
      scan("ones", 16'h3000, 16'h4200, 32'hFFFF_FFFF, 1'b0);

      for (int t = 0; t < 3; t++) begin
         fill_rand(16'h5000);
         scan("rand", 16'h5000, 16'h4300, $urandom, 1'b0);
      end

      // A start pulsed during READ with different inputs is ignored.
      fill_rand(16'h6000);
      scan("ignore", 16'h6000, 16'h4400, 32'h4000_0000, 1'b1);

      // Reset during WR1: outputs clear at once, and done never pulses.
      begin
         int cnt0; bit hit;
         fill_rand(16'h7000);
         @(negedge clk);
         hash_addr = 16'h7000; result_addr = 16'h4500; target = 32'hFFFF_FFFF; start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         hit = 1'b0;
         for (int c = 1; c <= 3 * N + 20; c++) begin
            @(posedge clk); #1;
            if (mem_we) begin hit = 1'b1; break; end
         end
         chk("rst_mid_reach_wr", {31'b0, hit}, 32'd1);
         cnt0 = done_cnt;
         reset = 1'b1; #1;
         chk("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
         chk("rst_mid_done", {31'b0, done}, 32'd0);
         chk("rst_mid_found", {31'b0, found}, 32'd0);
         chk("rst_mid_best_nonce", {16'b0, best_nonce}, 32'd0);
         chk("rst_mid_best_hash", best_hash, 32'd0);
         chk("rst_mid_mem_addr", {16'b0, mem_addr}, 32'd0);
         @(negedge clk) reset = 1'b0;
         repeat (8) @(posedge clk);
         #1 chk("rst_mid_no_done", 32'(done_cnt - cnt0), 32'd0);
         scan("rescan", 16'h7000, 16'h4500, 32'h8000_0000, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
